// File: rtl/irq_pin_ctrl_if.sv
// ----------------------------------------------------------------------------
// irq_pin_ctrl_if
//   CPLD CSR bus as seen by one peripheral. The bus master (CSR decoder or
//   testbench) drives the address, write data and the one-clock write strobe.
//   The peripheral returns read data combinationally from the address. It
//   returns 8'h00 for addresses it does not own, so several peripherals can
//   be OR-combined onto one bus.
//
//   csr_a   [4:0]  CSR address           master -> slave
//   csr_di  [7:0]  CSR write data        master -> slave
//   csr_we         write strobe, 1 clk   master -> slave
//   csr_do  [7:0]  CSR read data         slave  -> master
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

interface irq_pin_ctrl_if;
  logic [4:0] csr_a;
  logic [7:0] csr_di;
  logic       csr_we;
  logic [7:0] csr_do;

  modport master (
    output csr_a,
    output csr_di,
    output csr_we,
    input  csr_do
  );

  modport slave (
    input  csr_a,
    input  csr_di,
    input  csr_we,
    output csr_do
  );
endinterface

// File: rtl/irq_pin_ctrl.sv
// ----------------------------------------------------------------------------
// irq_pin_ctrl
//   Owns the shared CFG_RCW_SRC2 / CPLD_INTERRUPT pad. After reset the pad
//   drives the strap level. It keeps driving the strap for HOLD_CYCLES clocks
//   after reset is released, then becomes the aggregated interrupt output
//   for up to 8 sources. Those sources sit behind three CSRs:
//     BASE_ADDR+0  IE    RW    per-source enable (gates the pad only)
//     BASE_ADDR+1  IP    R/W1C pending, latched regardless of IE or phase
//     BASE_ADDR+2  MODE  RW    1 = rising-edge latched, 0 = level
//   The top level drives the pad as: pin_oe ? pin_out : 1'bz.
//
// Ports
//   clk             system clock
//   rst             synchronous reset, active-high
//   csr             CSR bus (slave side of irq_pin_ctrl_if)
//   irq_in          interrupt sources, active-high, synchronous to clk
//   force_recovery  1: the pad is never driven, so the external strap wins
//   pin_oe          pad output enable (combinational from force_recovery)
//   pin_out         pad output value (registered)
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module irq_pin_ctrl #(
  parameter logic [4:0] BASE_ADDR   = 5'h1c,
  parameter int         NUM_IRQS    = 8,
  parameter logic       STRAP_VAL   = 1'b0,
  parameter int         HOLD_CYCLES = 16,
  parameter logic       IRQ_ACT_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  irq_pin_ctrl_if.slave       csr,
  input  logic [NUM_IRQS-1:0] irq_in,
  input  logic                force_recovery,
  output logic                pin_oe,
  output logic                pin_out
);

  typedef enum logic [1:0] {
    ST_STRAP = 2'd0,  // in or just out of reset, driving the strap
    ST_HOLD  = 2'd1,  // strap held for the remaining HOLD_CYCLES-1 clocks
    ST_IRQ   = 2'd2   // pad is the interrupt output until the next reset
  } state_t;

  // Register bits at or above NUM_IRQS do not exist. They read 0 and ignore
  // writes.
  localparam logic [7:0] IRQ_MASK  = 8'((9'd1 << NUM_IRQS) - 9'd1);
  localparam logic [7:0] HOLD_LOAD = (HOLD_CYCLES == 0) ? 8'd0 : 8'(HOLD_CYCLES - 1);

  localparam logic [4:0] ADDR_IE   = BASE_ADDR;
  localparam logic [4:0] ADDR_IP   = BASE_ADDR + 5'd1;
  localparam logic [4:0] ADDR_MODE = BASE_ADDR + 5'd2;

  state_t     state_q, state_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;

  logic [7:0] ie_q;
  logic [7:0] ip_q;
  logic [7:0] mode_q;
  logic [7:0] prev_irq_q;

  logic [7:0] irq_ext;
  logic [7:0] ip_set;
  logic [7:0] ip_clr;
  logic [7:0] ip_d;
  logic       wr_ie;
  logic       wr_ip;
  logic       wr_mode;
  logic       irq_act;

  // --------------------------------------------------------------------------
  // Source conditioning
  // --------------------------------------------------------------------------
  // Widen the sources to the 8-bit register width. Missing sources read 0.
  // NOTE: every signal assigned in always_comb gets a default first. Without
  // the default, any path that skips an assignment infers a latch.
  always_comb begin
    irq_ext                 = 8'h00;
    irq_ext[NUM_IRQS-1:0]   = irq_in;
  end

  // --------------------------------------------------------------------------
  // CSR write decode
  // --------------------------------------------------------------------------
  assign wr_ie   = csr.csr_we && (csr.csr_a == ADDR_IE);
  assign wr_ip   = csr.csr_we && (csr.csr_a == ADDR_IP);
  assign wr_mode = csr.csr_we && (csr.csr_a == ADDR_MODE);

  // --------------------------------------------------------------------------
  // Pending logic
  // --------------------------------------------------------------------------
  // A level source sets its bit whenever it is high. An edge source sets its
  // bit only on a 0->1 transition.
  assign ip_set = irq_ext & (~mode_q | ~prev_irq_q);
  assign ip_clr = wr_ip ? csr.csr_di : 8'h00;

  // The set term is ORed in after the clear is applied. If a source fires in
  // the same clock as a W1C of its bit, the set wins. A level source that is
  // still high after a W1C therefore reads 1 again.
  assign ip_d = ((ip_q & ~ip_clr) | ip_set) & IRQ_MASK;

  // --------------------------------------------------------------------------
  // CSR registers
  // --------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments. Every flop then
  // samples values from before the edge, whatever the order of the blocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      ie_q       <= 8'h00;
      ip_q       <= 8'h00;
      mode_q     <= 8'h00;
      prev_irq_q <= 8'h00;
    end else begin
      if (wr_ie) begin
        ie_q <= csr.csr_di & IRQ_MASK;
      end
      if (wr_mode) begin
        mode_q <= csr.csr_di & IRQ_MASK;
      end
      ip_q       <= ip_d;
      // Sources are tracked in every phase, so an edge that arrives during
      // STRAP/HOLD is still recognised.
      prev_irq_q <= irq_ext;
    end
  end

  // --------------------------------------------------------------------------
  // Pad sequencing FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_STRAP;
      hold_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_STRAP: begin
        if (HOLD_CYCLES == 0) begin
          state_d = ST_IRQ;
        end else begin
          state_d    = ST_HOLD;
          hold_cnt_d = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q == 8'd0) begin
          state_d = ST_IRQ;
        end else begin
          hold_cnt_d = hold_cnt_q - 8'd1;
        end
      end
      ST_IRQ: begin
        state_d = ST_IRQ;
      end
      default: begin
        state_d    = ST_STRAP;
        hold_cnt_d = 8'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Pad drive
  // --------------------------------------------------------------------------
  assign irq_act = |(ip_q & ie_q);

  // pin_out is loaded from the upcoming state. The strap therefore occupies
  // exactly HOLD_CYCLES clocks after reset release: the STRAP->HOLD edge plus
  // HOLD_CYCLES-1 clocks in HOLD. IP/IE changes reach the pad one clock
  // after the registers update.
  always_ff @(posedge clk) begin
    if (rst) begin
      pin_out <= STRAP_VAL;
    end else if (state_d == ST_IRQ) begin
      pin_out <= irq_act ^ IRQ_ACT_LOW;
    end else begin
      pin_out <= STRAP_VAL;
    end
  end

  // Recovery mode only releases the pad. The FSM and the CSRs keep running,
  // so the pad resumes its correct value as soon as recovery is dropped.
  assign pin_oe = !force_recovery;

  // --------------------------------------------------------------------------
  // CSR read mux
  // --------------------------------------------------------------------------
  always_comb begin
    csr.csr_do = 8'h00;
    case (csr.csr_a)
      ADDR_IE:   csr.csr_do = ie_q;
      ADDR_IP:   csr.csr_do = ip_q;
      ADDR_MODE: csr.csr_do = mode_q;
      default:   csr.csr_do = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_irq_pin_ctrl.sv
`timescale 1ns/1ps

module tb_irq_pin_ctrl;

  localparam logic [4:0] BASE   = 5'h1c;
  localparam logic [4:0] A_IE   = BASE;
  localparam logic [4:0] A_IP   = BASE + 5'd1;
  localparam logic [4:0] A_MODE = BASE + 5'd2;
  localparam logic [4:0] A_OUT  = BASE + 5'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] irq_in = 8'h00;
  logic       force_recovery = 1'b0;
  logic       pin_oe;
  logic       pin_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  irq_pin_ctrl_if bus ();

  irq_pin_ctrl #(
    .BASE_ADDR   (BASE),
    .NUM_IRQS    (8),
    .STRAP_VAL   (1'b0),
    .HOLD_CYCLES (16),
    .IRQ_ACT_LOW (1'b1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .csr            (bus),
    .irq_in         (irq_in),
    .force_recovery (force_recovery),
    .pin_oe         (pin_oe),
    .pin_out        (pin_out)
  );

  // Combinational read, sampled mid-cycle.
  task automatic csr_rd(input logic [4:0] a, output logic [7:0] d);
    bus.csr_a = a;
    #1;
    d = bus.csr_do;
  endtask

  // One-clock write strobe. Returns at the falling edge after the write edge.
  task automatic csr_wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.csr_a  = a;
    bus.csr_di = d;
    bus.csr_we = 1'b1;
    @(negedge clk);
    bus.csr_we = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (pin_oe !== 1'b1 || pin_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_pad: oe=%b out=%b want oe=1 out=0", pin_oe, pin_out);
    end
    csr_rd(A_IE, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("FAIL reset_ie: got %h want 00", v); end
    csr_rd(A_IP, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("FAIL reset_ip: got %h want 00", v); end
    csr_rd(A_MODE, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("FAIL reset_mode: got %h want 00", v); end
    // Strap lasts exactly 16 clocks after release, then the pad goes idle high.
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      total++;
      if (pin_out !== 1'b0 || pin_oe !== 1'b1) begin
        bad++;
        $display("FAIL strap_hold[%0d]: oe=%b out=%b want oe=1 out=0", i, pin_oe, pin_out);
      end
    end
    @(negedge clk);
    total++;
    if (pin_out !== 1'b1) begin
      bad++;
      $display("FAIL irq_idle: out=%b want 1", pin_out);
    end
  endtask

  task automatic test_edge_latch();
    logic [7:0] v;
    csr_wr(A_IE, 8'h01);
    csr_wr(A_MODE, 8'h01);
    irq_in = 8'h01;
    @(negedge clk);
    irq_in = 8'h00;
    csr_rd(A_IP, v);
    total++;
    if (v !== 8'h01) begin bad++; $display("FAIL edge_ip_set: got %h want 01", v); end
    total++;
    if (pin_out !== 1'b1) begin bad++; $display("FAIL edge_pad_latency: out=%b want 1", pin_out); end
    @(negedge clk);
    total++;
    if (pin_out !== 1'b0) begin bad++; $display("FAIL edge_pad_assert: out=%b want 0", pin_out); end
    csr_rd(A_IP, v);
    total++;
    if (v !== 8'h01) begin bad++; $display("FAIL edge_ip_held: got %h want 01", v); end
    csr_wr(A_IP, 8'h01);
    csr_rd(A_IP, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("FAIL edge_w1c: got %h want 00", v); end
    @(negedge clk);
    total++;
    if (pin_out !== 1'b1) begin bad++; $display("FAIL edge_pad_deassert: out=%b want 1", pin_out); end
  endtask

  task automatic test_level_w1c();
    logic [7:0] v;
    csr_wr(A_MODE, 8'h00);
    csr_wr(A_IE, 8'h08);
    irq_in = 8'h08;
    @(negedge clk);
    csr_rd(A_IP, v);
    total++;
    if (v !== 8'h08) begin bad++; $display("FAIL level_set: got %h want 08", v); end
    @(negedge clk);
    total++;
    if (pin_out !== 1'b0) begin bad++; $display("FAIL level_pad: out=%b want 0", pin_out); end
    csr_wr(A_IP, 8'h08);
    csr_rd(A_IP, v);
    total++;
    if (v !== 8'h08) begin bad++; $display("FAIL level_reset_after_w1c: got %h want 08", v); end
    irq_in = 8'h00;
    @(negedge clk);
    csr_wr(A_IP, 8'h08);
    csr_rd(A_IP, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("FAIL level_w1c_clear: got %h want 00", v); end
    @(negedge clk);
    total++;
    if (pin_out !== 1'b1) begin bad++; $display("FAIL level_pad_deassert: out=%b want 1", pin_out); end
  endtask

  task automatic test_set_wins();
    logic [7:0] v;
    csr_wr(A_MODE, 8'h08);
    irq_in = 8'h08;
    @(negedge clk);
    irq_in = 8'h00;
    @(negedge clk);
    csr_rd(A_IP, v);
    total++;
    if (v !== 8'h08) begin bad++; $display("FAIL setwins_pre: got %h want 08", v); end
    // A new rising edge and a W1C of the same bit land on one clock.
    bus.csr_a  = A_IP;
    bus.csr_di = 8'h08;
    bus.csr_we = 1'b1;
    irq_in     = 8'h08;
    @(negedge clk);
    bus.csr_we = 1'b0;
    csr_rd(A_IP, v);
    total++;
    if (v !== 8'h08) begin bad++; $display("FAIL setwins_same_clk: got %h want 08", v); end
    // The source is still high but has no new edge, so the W1C now clears.
    csr_wr(A_IP, 8'h08);
    csr_rd(A_IP, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("FAIL setwins_edge_no_reset: got %h want 00", v); end
    irq_in = 8'h00;
    @(negedge clk);
    total++;
    if (pin_out !== 1'b1) begin bad++; $display("FAIL setwins_pad: out=%b want 1", pin_out); end
  endtask

  task automatic test_force_recovery();
    logic [7:0] v;
    force_recovery = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (pin_oe !== 1'b0 || pin_out !== 1'b0) begin
      bad++;
      $display("FAIL force_reset: oe=%b out=%b want oe=0 out=0", pin_oe, pin_out);
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    total++;
    if (pin_oe !== 1'b0) begin bad++; $display("FAIL force_irq_oe: oe=%b want 0", pin_oe); end
    csr_wr(A_IE, 8'h01);
    irq_in = 8'h01;
    @(negedge clk);
    irq_in = 8'h00;
    @(negedge clk);
    csr_rd(A_IP, v);
    total++;
    if (v !== 8'h01) begin bad++; $display("FAIL force_ip_latch: got %h want 01", v); end
    total++;
    if (pin_oe !== 1'b0) begin bad++; $display("FAIL force_oe_pending: oe=%b want 0", pin_oe); end
    force_recovery = 1'b0;
    #1;
    total++;
    if (pin_oe !== 1'b1 || pin_out !== 1'b0) begin
      bad++;
      $display("FAIL force_release: oe=%b out=%b want oe=1 out=0", pin_oe, pin_out);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    csr_wr(A_IE, 8'hff);
    csr_wr(A_MODE, 8'hff);
    irq_in = 8'hff;
    @(negedge clk);
    irq_in = 8'h00;
    csr_rd(A_IP, v);
    total++;
    if (v !== 8'hff) begin bad++; $display("FAIL mid_ip_all: got %h want ff", v); end
    // A write outside the register window must not disturb IE.
    csr_wr(A_OUT, 8'h00);
    csr_rd(A_IE, v);
    total++;
    if (v !== 8'hff) begin bad++; $display("FAIL mid_oob_write: ie=%h want ff", v); end
    csr_rd(5'h00, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("FAIL mid_foreign_read: got %h want 00", v); end
    total++;
    if (pin_out !== 1'b0) begin bad++; $display("FAIL mid_pad_assert: out=%b want 0", pin_out); end
    rst = 1'b1;
    @(negedge clk);
    csr_rd(A_IE, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("FAIL mid_rst_ie: got %h want 00", v); end
    csr_rd(A_IP, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("FAIL mid_rst_ip: got %h want 00", v); end
    csr_rd(A_MODE, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("FAIL mid_rst_mode: got %h want 00", v); end
    total++;
    if (pin_out !== 1'b0 || pin_oe !== 1'b1) begin
      bad++;
      $display("FAIL mid_rst_pad: oe=%b out=%b want oe=1 out=0", pin_oe, pin_out);
    end
    csr_rd(A_OUT, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("FAIL mid_oob_read: got %h want 00", v); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.csr_a  = 5'h00;
    bus.csr_di = 8'h00;
    bus.csr_we = 1'b0;
    test_reset();
    test_edge_latch();
    test_level_w1c();
    test_set_wins();
    test_force_recovery();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
